// File: rtl/subtractor_32bit.sv
// Registered 32-bit two's-complement subtractor (y = a - b) with borrow, overflow,
// zero and negative flags; one-cycle latency, one operation accepted per cycle.
module subtractor_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH:1]   a,
    input  logic [WIDTH:1]   b,
    output logic [WIDTH:1]   y,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // bin[i] is the borrow into cell i; bin[WIDTH+1] is the borrow out of the MSB.
    logic [WIDTH+1:1] bin;
    logic [WIDTH:1]   d;
    logic             ovf_c;

    assign bin[1] = 1'b0;

    for (genvar i = 1; i <= WIDTH; i++) begin : g_cell
        assign d[i]       = a[i] ^ b[i] ^ bin[i];
        assign bin[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin[i]);
    end

    assign ovf_c = (a[WIDTH] != b[WIDTH]) && (d[WIDTH] != a[WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            negative <= 1'b0;
        end else begin
            y        <= d;
            borrow   <= bin[WIDTH + 1];
            overflow <= ovf_c;
            zero     <= (d == '0);
            negative <= d[WIDTH];
        end
    end

endmodule

// File: tb/tb_subtractor_32bit.sv
// Self-checking bench for subtractor_32bit: directed boundary cases, a random
// one-per-cycle stream against an arithmetic reference model, and mid-stream reset.
module tb_subtractor_32bit;

    logic        clk;
    logic        rst;
    logic [32:1] a;
    logic [32:1] b;
    logic [32:1] y;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        negative;

    int n_checks = 0;
    int n_fail   = 0;

    subtractor_32bit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .y        (y),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ey, input logic eb,
                             input logic eo, input logic ez, input logic en);
        check({tag, ".y"},        y,                ey);
        check({tag, ".borrow"},   {31'd0, borrow},   {31'd0, eb});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, ".zero"},     {31'd0, zero},     {31'd0, ez});
        check({tag, ".negative"}, {31'd0, negative}, {31'd0, en});
    endtask

    // Reference: plain unsigned/signed arithmetic on wide integers.
    task automatic model_check(input string tag, input logic [31:0] ma, input logic [31:0] mb);
        longint    sa;
        longint    sb;
        longint    sd;
        logic [31:0] ey;
        logic      eo;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        sd = sa - sb;
        eo = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        ey = ma - mb;
        check_all(tag, ey, (ma < mb), eo, (ey == 32'd0), ey[31]);
    endtask

    // Apply operands, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [31:0] na, input logic [31:0] nb);
        rst = r;
        a   = na;
        b   = nb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        a   = '0;
        b   = '0;

        for (int i = 0; i < 2; i++) begin
            step(1'b1, $urandom, $urandom);
            check_all("reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        step(1'b0, 32'd5, 32'd3);
        check_all("five_minus_three", 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 32'hFFFFFFFB, 32'h00000003);
        check_all("neg_operand", 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b1);

        step(1'b0, 32'h00000000, 32'h00000001);
        check_all("zero_minus_one", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        step(1'b0, 32'h12345678, 32'h12345678);
        check_all("equal", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        step(1'b0, 32'h80000000, 32'h00000001);
        check_all("min_minus_one", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        step(1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF);
        check_all("max_minus_neg1", 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back random stream, full borrow ripple injected mid-way.
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                ra = 32'h00000000;
                rb = 32'h00000001;
            end else if (i % 7 == 0) begin
                ra = $urandom;
                rb = ra;
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            step(1'b0, ra, rb);
            model_check("stream", ra, rb);
        end

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 10) begin
                step(1'b1, ra, rb);
                check_all("mid_reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                step(1'b0, ra, rb);
                model_check("post_reset_stream", ra, rb);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
